sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DEPTH, default 16: storage entries; SHALL be a power of two, at least 4.
REQ-002 Parameter DATA_WIDTH, default 8: data bits per entry.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: almost_full threshold in entries.
REQ-004 Parameter AE_LEVEL, default 2: almost_empty threshold in entries.
REQ-005 Parameter FWFT, default 0: 0 = standard read mode, 1 = first-word-fall-through mode.
REQ-006 Ports, in order:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset, sampled on posedge clk.
- w_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- r_en  in  1  read request (pop in FWFT mode).
- data_out  out  DATA_WIDTH  read data.
- rd_valid  out  1  data_out carries newly read data (standard mode).
- full, empty  out  1 each  occupancy flags.
- almost_full, almost_empty  out  1 each  threshold flags.
- count  out  clog2(DEPTH)+1  current occupancy.
- write_error, read_error  out  1 each  one-cycle rejection pulses.

Function
REQ-007 Pointers SHALL be clog2(DEPTH)+1 bits wide; the low bits address storage and the MSB is the wrap bit.
REQ-008 empty SHALL be asserted when the pointers are equal; full SHALL be asserted when the address bits are equal and the wrap bits differ.
REQ-009 count SHALL equal wptr minus rptr, modulo 2^(clog2(DEPTH)+1); its range is 0..DEPTH.
REQ-010 All flags and count SHALL be registered and SHALL reflect the state after the previous clock edge.
REQ-011 A write SHALL be accepted when w_en=1 and (full=0, or full=1 with an accepted read in the same cycle).
REQ-012 A read SHALL be accepted when r_en=1 and empty=0; a simultaneous write never makes a read acceptable while empty.
REQ-013 A rejected write SHALL assert write_error for exactly the next cycle; it SHALL NOT change storage, pointers, or count.
REQ-014 A rejected read SHALL assert read_error for exactly the next cycle; it SHALL NOT change pointers, data_out, or rd_valid.
REQ-015 Standard mode (FWFT=0):
- data_out SHALL be registered and SHALL update one cycle after an accepted read.
- rd_valid SHALL pulse in that same cycle.
- data_out SHALL hold its value otherwise.
REQ-016 FWFT mode (FWFT=1):
- data_out SHALL present the head entry whenever empty=0.
- r_en SHALL pop the head; the next entry appears the following cycle.
- rd_valid SHALL equal the inverse of empty.
REQ-017 FWFT write-to-read latency: a word written into an empty FIFO at edge N SHALL be on data_out with empty=0 after edge N.
REQ-018 A simultaneous accepted read and write SHALL leave count unchanged and SHALL advance both pointers.
REQ-019 Pointers SHALL wrap from DEPTH-1 to 0 with the wrap bit toggling; no entry is lost across the wrap.
REQ-020 almost_full SHALL be asserted when count >= AF_LEVEL; almost_empty SHALL be asserted when count <= AE_LEVEL.

Reset
REQ-021 While rst=1 at posedge clk, the block SHALL reset:
- pointers and count to 0;
- empty=1, almost_empty=1;
- full=0, almost_full=0;
- rd_valid=0, write_error=0, read_error=0;
- data_out to 0.
REQ-022 Storage contents are not reset.
REQ-023 Reset SHALL take priority over w_en and r_en in the same cycle.
REQ-024 Reset asserted mid-operation SHALL discard all stored entries.

Structure
REQ-025 Package fifo_pkg SHALL hold the pointer-width function, default parameter constants, and a mode enum {FIFO_STD, FIFO_FWFT}.
REQ-026 Storage SHALL be a sub-module named sync_fifo_ram with:
- one synchronous write port;
- one read port, registered when FWFT=0 and combinational when FWFT=1.
REQ-027 Pointer, flag, count, and error logic SHALL reside in sync_fifo.

Verification (DEPTH=8, DATA_WIDTH=8)
REQ-028 Fill: after reset, write 0x01..0x08 over 8 cycles -> full=1 and count=8 after the 8th edge; almost_full first asserts at count=6.
REQ-029 Overflow: while full, w_en=1 with 0xAA -> write_error pulses 1 cycle, count stays 8, later reads return 0x01..0x08 with no 0xAA.
REQ-030 Underflow: when empty, r_en=1 -> read_error pulses 1 cycle, data_out unchanged, rd_valid=0.
REQ-031 Full with simultaneous access: while full, w_en=1 (0x55) and r_en=1 -> both accepted, count stays 8, and 0x55 is read last.
REQ-032 Wrap and FWFT: with FWFT=1, stream 20 words through with count between 1 and 3 -> data matches in order, and data_out=0x10 appears the cycle after writing 0x10 into an empty FIFO.
REQ-033 Mid-operation reset: with count=5, assert rst for 1 cycle together with w_en=1 -> count=0, empty=1, and the next read is rejected with read_error.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants, read-mode enum and pointer sizing for the synchronous FIFO.
package fifo_pkg;

  localparam int DEF_DEPTH      = 16;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_AE_LEVEL   = 2;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Address bits plus one wrap bit, so full and empty stay distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: one synchronous write port and one read port, which is
// registered in standard mode and combinational in first-word-fall-through mode.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int         DEPTH      = DEF_DEPTH,
  parameter int         DATA_WIDTH = DEF_DATA_WIDTH,
  parameter fifo_mode_e MODE       = FIFO_STD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic                       re,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]      rdata
);

  // Storage is intentionally left out of reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (MODE == FIFO_FWFT) begin : g_comb_read
      logic unused_rd_ctrl;
      assign unused_rd_ctrl = rst ^ re;
      assign rdata = mem[raddr];
    end else begin : g_reg_read
      // A same-address write in this cycle lands after the read, so the old head is returned.
      always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
      end
    end
  endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: wrap-bit pointers, registered flags and count, and
// one-cycle error pulses for rejected requests.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = DEF_AE_LEVEL,
  parameter int FWFT       = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          w_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          r_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          rd_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [ptr_width(DEPTH)-1:0]   count,
  output logic                          write_error,
  output logic                          read_error
);

  localparam int             PW    = ptr_width(DEPTH);
  localparam int             AW    = PW - 1;
  localparam fifo_mode_e     MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [PW-1:0]  AF_TH = PW'(AF_LEVEL);
  localparam logic [PW-1:0]  AE_TH = PW'(AE_LEVEL);

  logic [PW-1:0]         wptr, rptr, wptr_nxt, rptr_nxt, count_nxt;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Request semantics: a read is taken when r_en=1 and the FIFO is not empty;
  // a write is taken when w_en=1 and the FIFO is not full, or is full but a read
  // is taken in the same cycle. A request that is not taken is dropped and
  // reported by a one-cycle error pulse; there is no back-pressure retry.
  always_comb begin
    rd_acc    = r_en && !empty;
    wr_acc    = w_en && (!full || rd_acc);
    wptr_nxt  = wptr + {{AW{1'b0}}, wr_acc};
    rptr_nxt  = rptr + {{AW{1'b0}}, rd_acc};
    count_nxt = wptr_nxt - rptr_nxt;
  end

  // Flags are computed from next-state pointers so they are valid right after the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      write_error  <= 1'b0;
      read_error   <= 1'b0;
    end else begin
      wptr         <= wptr_nxt;
      rptr         <= rptr_nxt;
      count        <= count_nxt;
      empty        <= (wptr_nxt == rptr_nxt);
      full         <= (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]) &&
                      (wptr_nxt[AW] != rptr_nxt[AW]);
      almost_full  <= (count_nxt >= AF_TH);
      almost_empty <= (count_nxt <= AE_TH);
      write_error  <= w_en && !wr_acc;
      read_error   <= r_en && !rd_acc;
    end
  end

  sync_fifo_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MODE       (MODE)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wptr[AW-1:0]),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rptr[AW-1:0]),
    .rdata (ram_rdata)
  );

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft_out
      // Mask the unreset storage so data_out reads zero while empty.
      assign data_out = empty ? '0 : ram_rdata;
      assign rd_valid = !empty;
    end else begin : g_std_out
      assign data_out = ram_rdata;
      always_ff @(posedge clk) begin
        if (rst) rd_valid <= 1'b0;
        else     rd_valid <= rd_acc;
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench: a standard-mode and a FWFT-mode FIFO (DEPTH=8) share one stimulus stream.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst, w_en, r_en;
  logic [7:0] data_in;

  logic [7:0] s_data_out, f_data_out;
  logic       s_rd_valid, f_rd_valid;
  logic       s_full, s_empty, s_af, s_ae, s_werr, s_rerr;
  logic       f_full, f_empty, f_af, f_ae, f_werr, f_rerr;
  logic [3:0] s_count, f_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sync_fifo #(.DEPTH(8), .DATA_WIDTH(8), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(s_data_out), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .write_error(s_werr), .read_error(s_rerr)
  );

  sync_fifo #(.DEPTH(8), .DATA_WIDTH(8), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(f_data_out), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .write_error(f_werr), .read_error(f_rerr)
  );

  // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    w_en = w; data_in = d; r_en = r;
    @(posedge clk); #1;
    w_en = 1'b0; r_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b1, 8'h77, 1'b1);
    cyc(1'b1, 8'h78, 1'b1);
    rst = 1'b0;
    n_cmp++;
    if ({s_count, s_empty, s_ae, s_full, s_af, s_rd_valid, s_werr, s_rerr} !== {4'd0, 7'b1100000}) begin
      n_err++;
      $display("FAIL reset_std_flags: got cnt=%0d e=%b ae=%b f=%b af=%b v=%b we=%b re=%b, want cnt=0 e=1 ae=1 others 0",
               s_count, s_empty, s_ae, s_full, s_af, s_rd_valid, s_werr, s_rerr);
    end
    n_cmp++;
    if ({f_count, f_empty, f_ae, f_full, f_af, f_rd_valid} !== {4'd0, 5'b11000}) begin
      n_err++;
      $display("FAIL reset_fwft_flags: got cnt=%0d e=%b ae=%b f=%b af=%b v=%b, want cnt=0 e=1 ae=1 others 0",
               f_count, f_empty, f_ae, f_full, f_af, f_rd_valid);
    end
    n_cmp++;
    if (s_data_out !== 8'h00 || f_data_out !== 8'h00) begin
      n_err++;
      $display("FAIL reset_data_out: got std=%h fwft=%h, want 00 00", s_data_out, f_data_out);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      exp_q.push_back(8'(i));
      n_cmp++;
      if (s_count !== 4'(i) || s_full !== (i == 8) || s_af !== (i >= 6) ||
          s_ae !== (i <= 2) || s_empty !== 1'b0) begin
        n_err++;
        $display("FAIL fill_%0d: got cnt=%0d f=%b af=%b ae=%b e=%b, want cnt=%0d f=%b af=%b ae=%b e=0",
                 i, s_count, s_full, s_af, s_ae, s_empty, i, (i == 8), (i >= 6), (i <= 2));
      end
    end
  endtask

  task automatic test_overflow();
    cyc(1'b1, 8'hAA, 1'b0);
    n_cmp++;
    if (s_werr !== 1'b1 || s_count !== 4'd8 || s_full !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_pulse: got werr=%b cnt=%0d f=%b, want werr=1 cnt=8 f=1", s_werr, s_count, s_full);
    end
    cyc(1'b0, 8'h00, 1'b0);
    n_cmp++;
    if (s_werr !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_pulse_end: got werr=%b, want 0", s_werr);
    end
    while (exp_q.size() > 0) begin
      logic [7:0] exp_d;
      exp_d = exp_q.pop_front();
      cyc(1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (s_rd_valid !== 1'b1 || s_data_out !== exp_d) begin
        n_err++;
        $display("FAIL overflow_read: got v=%b d=%h, want v=1 d=%h", s_rd_valid, s_data_out, exp_d);
      end
    end
    cyc(1'b0, 8'h00, 1'b0);
    n_cmp++;
    if (s_rd_valid !== 1'b0 || s_data_out !== 8'h08 || s_empty !== 1'b1 || s_count !== 4'd0) begin
      n_err++;
      $display("FAIL overflow_drained: got v=%b d=%h e=%b cnt=%0d, want v=0 d=08 e=1 cnt=0",
               s_rd_valid, s_data_out, s_empty, s_count);
    end
  endtask

  task automatic test_underflow();
    cyc(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (s_rerr !== 1'b1 || s_rd_valid !== 1'b0 || s_data_out !== 8'h08 || s_count !== 4'd0) begin
      n_err++;
      $display("FAIL underflow_pulse: got rerr=%b v=%b d=%h cnt=%0d, want rerr=1 v=0 d=08 cnt=0",
               s_rerr, s_rd_valid, s_data_out, s_count);
    end
    cyc(1'b0, 8'h00, 1'b0);
    n_cmp++;
    if (s_rerr !== 1'b0 || s_data_out !== 8'h08) begin
      n_err++;
      $display("FAIL underflow_pulse_end: got rerr=%b d=%h, want rerr=0 d=08", s_rerr, s_data_out);
    end
  endtask

  task automatic test_full_simul();
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 8'(8'h30 + i), 1'b0);
      exp_q.push_back(8'(8'h30 + i));
    end
    n_cmp++;
    if (s_full !== 1'b1 || s_count !== 4'd8) begin
      n_err++;
      $display("FAIL wrap_fill: got f=%b cnt=%0d, want f=1 cnt=8", s_full, s_count);
    end
    cyc(1'b1, 8'h55, 1'b1);
    exp_q.push_back(8'h55);
    n_cmp++;
    if (s_werr !== 1'b0 || s_rerr !== 1'b0 || s_count !== 4'd8 || s_full !== 1'b1 ||
        s_rd_valid !== 1'b1 || s_data_out !== 8'h31) begin
      n_err++;
      $display("FAIL full_simul: got we=%b re=%b cnt=%0d f=%b v=%b d=%h, want 0 0 8 1 1 31",
               s_werr, s_rerr, s_count, s_full, s_rd_valid, s_data_out);
    end
    void'(exp_q.pop_front());
    while (exp_q.size() > 0) begin
      logic [7:0] exp_d;
      exp_d = exp_q.pop_front();
      cyc(1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (s_rd_valid !== 1'b1 || s_data_out !== exp_d) begin
        n_err++;
        $display("FAIL full_simul_read: got v=%b d=%h, want v=1 d=%h", s_rd_valid, s_data_out, exp_d);
      end
    end
    n_cmp++;
    if (s_empty !== 1'b1 || s_data_out !== 8'h55) begin
      n_err++;
      $display("FAIL full_simul_last: got e=%b d=%h, want e=1 d=55", s_empty, s_data_out);
    end
  endtask

  task automatic test_fwft_stream();
    int p;
    cyc(1'b1, 8'h10, 1'b0);
    n_cmp++;
    if (f_empty !== 1'b0 || f_rd_valid !== 1'b1 || f_data_out !== 8'h10) begin
      n_err++;
      $display("FAIL fwft_latency: got e=%b v=%b d=%h, want e=0 v=1 d=10", f_empty, f_rd_valid, f_data_out);
    end
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h12, 1'b0);
    p = 0;
    for (int k = 3; k < 20; k++) begin
      cyc(1'b1, 8'(8'h10 + k), 1'b1);
      p++;
      n_cmp++;
      if (f_data_out !== 8'(8'h10 + p) || f_count !== 4'd3) begin
        n_err++;
        $display("FAIL fwft_stream_%0d: got d=%h cnt=%0d, want d=%h cnt=3", k, f_data_out, f_count, 8'(8'h10 + p));
      end
    end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 8'h00, 1'b1);
      p++;
      if (p < 20) begin
        n_cmp++;
        if (f_data_out !== 8'(8'h10 + p) || f_rd_valid !== 1'b1) begin
          n_err++;
          $display("FAIL fwft_drain_%0d: got d=%h v=%b, want d=%h v=1", k, f_data_out, f_rd_valid, 8'(8'h10 + p));
        end
      end
    end
    n_cmp++;
    if (f_empty !== 1'b1 || f_rd_valid !== 1'b0 || f_count !== 4'd0) begin
      n_err++;
      $display("FAIL fwft_empty: got e=%b v=%b cnt=%0d, want e=1 v=0 cnt=0", f_empty, f_rd_valid, f_count);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0);
    n_cmp++;
    if (s_count !== 4'd5) begin
      n_err++;
      $display("FAIL mid_reset_pre: got cnt=%0d, want 5", s_count);
    end
    rst = 1'b1;
    cyc(1'b1, 8'hEE, 1'b0);
    rst = 1'b0;
    n_cmp++;
    if (s_count !== 4'd0 || s_empty !== 1'b1 || s_data_out !== 8'h00 || f_empty !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: got cnt=%0d e=%b d=%h fe=%b, want cnt=0 e=1 d=00 fe=1",
               s_count, s_empty, s_data_out, f_empty);
    end
    cyc(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (s_rerr !== 1'b1 || s_rd_valid !== 1'b0 || f_rerr !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_read: got rerr=%b v=%b frerr=%b, want 1 0 1", s_rerr, s_rd_valid, f_rerr);
    end
  endtask

  initial begin
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_full_simul();
    test_fwft_stream();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
